decoder_frame_ctrl: RTL and testbench
=====================================

Name: decoder_frame_ctrl

Overview:
- Frame-level sequencer for the RX Hamming decoder that follows QPSK demodulation.
- Accepts demodulated dibits over a valid/ready handshake and drives the decoder's `in`/`demod_en` in strict 4-dibit codeword groups, keeping the decoder's internal dibit counter aligned.
- Samples each decoded nibble after the decoder latency and packs nibble pairs into bytes on a valid/ready output.
- Bounds every frame to NUM_CW codewords and flags frame completion.

Parameters:
- NUM_CW, 16: codewords per frame; legal range 1..255.
- DEC_LAT, 2: edges from the decoder accepting the 4th dibit to `dec_out` being valid and stable; legal range ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
- sym_data  in  2  demodulated dibit.
- sym_valid  in  1  sym_data is valid.
- sym_ready  out  1  block accepts a dibit this cycle.
- dec_in  out  2  to decoder `in`.
- dec_en  out  1  to decoder `demod_en`.
- dec_out  in  4  decoder corrected nibble.
- byte_data  out  8  packed byte; first nibble of the pair is in [3:0], second in [7:4].
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  sink accepts the byte.
- frame_busy  out  1  high from leaving IDLE until the return to IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset:
  - Takes precedence everywhere, including mid-frame.
  - state=IDLE; all counters 0; byte_data=0; byte_valid=0; frame_busy=0; frame_done=0; sym_ready=0; dec_en=0.
  - The decoder shares `reset`, so both restart aligned.
- States: IDLE, FEED, WAIT, CAPT, STALL, DONE.
- IDLE:
  - sym_ready=0.
  - frame_start=1 → FEED next cycle; cw_cnt=0, dibit_cnt=0, nib_sel=0.
  - A sym_valid in the same cycle as frame_start is not accepted.
- FEED:
  - sym_ready=1.
  - Combinational pass-through: dec_en = sym_valid & sym_ready, dec_in = sym_data.
  - Each accept increments dibit_cnt (0..3).
  - Gaps in sym_valid stall FEED with dec_en=0.
  - The 4th accept clears dibit_cnt → WAIT.
- WAIT:
  - sym_ready=0, dec_en=0.
  - dec_out is sampled at the edge exactly DEC_LAT edges after the edge that accepted the 4th dibit; this sample ends WAIT → CAPT.
- CAPT (one cycle):
  - nib_sel=0: hold the nibble in nib_lo; nib_sel=1; cw_cnt++.
  - nib_sel=1: form {dec_nibble, nib_lo}; nib_sel=0; cw_cnt++.
  - Byte completes when nib_sel=1, or when nib_sel=0 and this was codeword NUM_CW (odd NUM_CW): last byte = {4'b0000, nibble}.
  - On byte completion: if the output register is free, or byte_valid & byte_ready this cycle, load byte_data and set byte_valid at the next edge; otherwise go to STALL holding the byte.
  - Next state after a load: cw_cnt==NUM_CW → DONE; else → FEED.
- STALL:
  - sym_ready=0.
  - Waits for byte_ready; loads the held byte at the edge where byte_valid & byte_ready, then follows the CAPT next-state rule.
- Output handshake:
  - byte_valid stays high and byte_data stable until byte_valid & byte_ready.
  - A byte cleared and a new byte loaded on the same edge leaves byte_valid=1.
- DONE (one cycle):
  - frame_done=1.
  - The last byte is already in the output register; byte_valid may still be high.
  - Next state IDLE.
- frame_busy=1 in every state except IDLE.
- frame_start outside IDLE is ignored, with no effect on counters.
- Throughput: one codeword per 4 + DEC_LAT + 1 cycles minimum. No dibit is ever passed to the decoder outside FEED.

Test Plan:
- Single frame, NUM_CW=2, DEC_LAT=2, decoder model returning 4'hA then 4'h5, continuous sym_valid, byte_ready=1 → dec_en high for exactly 8 cycles in two groups of 4 separated by WAIT/CAPT; byte_data=8'h5A with byte_valid one cycle; frame_done pulses once; frame_busy drops after DONE.
- sym_valid toggling 1/0 every cycle during FEED → dec_en asserted only on accept cycles, exactly 4 per codeword; bytes identical to the continuous case.
- Backpressure, NUM_CW=4: byte_ready=0 for 20 cycles after the first byte → second byte held in STALL with sym_ready=0; both bytes delivered in order once ready rises; no dibit lost or duplicated.
- Odd frame, NUM_CW=3, nibbles 1,2,3 → bytes 8'h21 then 8'h03; frame_done once.
- frame_start pulsed during FEED of codeword 1 → ignored; frame still ends after exactly NUM_CW codewords.
- reset asserted after 2 dibits of a codeword → next cycle IDLE with all outputs 0. New frame_start then decodes correctly with the decoder realigned (first byte equals the expected value).

Source files
------------

// File: rtl/decoder_frame_ctrl.sv
// Frame sequencer between QPSK demod and Hamming decoder: feeds 4-dibit groups, captures nibbles, packs bytes.
// Latency: one codeword every 4 + DEC_LAT + 1 cycles; a byte appears the cycle after its second (or odd last) nibble is captured.
// Backpressure: byte_ready low holds byte_valid/byte_data; a second completed byte parks in STALL with sym_ready low.
module decoder_frame_ctrl #(
  parameter int NUM_CW  = 16,
  parameter int DEC_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [1:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [1:0] dec_in,
  output logic       dec_en,
  input  logic [3:0] dec_out,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_CAPT,
    S_STALL,
    S_DONE
  } state_t;

  // Latency counter only needs to reach DEC_LAT-1.
  localparam int             LW       = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;
  localparam logic [LW-1:0]  LAT_LAST = LW'(DEC_LAT - 1);
  localparam logic [7:0]     CW_LAST  = 8'(NUM_CW - 1);
  localparam logic [7:0]     CW_END   = 8'(NUM_CW);

  state_t        r_state;
  state_t        w_next;

  logic [7:0]    r_cw_cnt;
  logic [1:0]    r_dibit_cnt;
  logic          r_nib_sel;
  logic [3:0]    r_nib_lo;
  logic [3:0]    r_dec_nib;
  logic [LW-1:0] r_lat_cnt;
  logic [7:0]    r_hold;
  logic [7:0]    r_byte_data;
  logic          r_byte_valid;

  logic          w_accept;
  logic          w_last_dibit;
  logic          w_sample;
  logic          w_byte_cmpl;
  logic [7:0]    w_byte_val;
  logic          w_out_free;
  logic          w_load;
  logic [7:0]    w_load_dat;

  // A dibit reaches the decoder only while feeding; reset blocks it so the decoder restarts clean.
  assign w_accept     = (r_state == S_FEED) & sym_valid & ~reset;
  assign w_last_dibit = w_accept & (r_dibit_cnt == 2'd3);
  assign w_sample     = (r_state == S_WAIT) & (r_lat_cnt == LAT_LAST);

  // A byte closes on the second nibble, or on the lone nibble of an odd-length frame.
  assign w_byte_cmpl  = r_nib_sel | (r_cw_cnt == CW_LAST);
  assign w_byte_val   = r_nib_sel ? {r_dec_nib, r_nib_lo} : {4'h0, r_dec_nib};
  assign w_out_free   = ~r_byte_valid | byte_ready;
  assign w_load       = ((r_state == S_CAPT) & w_byte_cmpl & w_out_free) |
                        ((r_state == S_STALL) & byte_ready);
  assign w_load_dat   = (r_state == S_STALL) ? r_hold : w_byte_val;

  assign byte_data    = r_byte_data;
  assign byte_valid   = r_byte_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and decoder-facing outputs.
  always_comb begin
    w_next     = r_state;
    sym_ready  = 1'b0;
    dec_en     = 1'b0;
    dec_in     = sym_data;
    frame_busy = (r_state != S_IDLE);
    frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) w_next = S_FEED;
      end
      S_FEED: begin
        sym_ready = ~reset;
        dec_en    = w_accept;
        if (w_last_dibit) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_sample) w_next = S_CAPT;
      end
      S_CAPT: begin
        if (!w_byte_cmpl)    w_next = S_FEED;
        else if (w_out_free) w_next = (r_cw_cnt == CW_LAST) ? S_DONE : S_FEED;
        else                 w_next = S_STALL;
      end
      S_STALL: begin
        // cw_cnt was already advanced in CAPT.
        if (byte_ready) w_next = (r_cw_cnt == CW_END) ? S_DONE : S_FEED;
      end
      S_DONE: begin
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame counters, latency timer and nibble pairing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cw_cnt    <= '0;
      r_dibit_cnt <= '0;
      r_nib_sel   <= 1'b0;
      r_nib_lo    <= '0;
      r_dec_nib   <= '0;
      r_lat_cnt   <= '0;
      r_hold      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_cw_cnt    <= '0;
            r_dibit_cnt <= '0;
            r_nib_sel   <= 1'b0;
          end
        end
        S_FEED: begin
          // The 4th accept wraps the count back to 0 for the next codeword.
          if (w_accept) r_dibit_cnt <= r_dibit_cnt + 2'd1;
          r_lat_cnt <= '0;
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
          if (w_sample) r_dec_nib <= dec_out;
        end
        S_CAPT: begin
          r_cw_cnt  <= r_cw_cnt + 8'd1;
          r_nib_sel <= ~w_byte_cmpl;
          if (!r_nib_sel) r_nib_lo <= r_dec_nib;
          if (w_byte_cmpl && !w_out_free) r_hold <= w_byte_val;
        end
        default: ;
      endcase
    end
  end

  // Output register: a load on the same edge as an accept keeps byte_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
    end else if (w_load) begin
      r_byte_data  <= w_load_dat;
      r_byte_valid <= 1'b1;
    end else if (r_byte_valid && byte_ready) begin
      r_byte_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_frame_ctrl.sv
// Bench for decoder_frame_ctrl: three instances (NUM_CW 2, 3, 4) each with a simple decoder stand-in.
// The stand-in decodes a codeword's nibble from its first two dibits and presents it DEC_LAT-1 edges after the 4th dibit.
// Expected bytes come from the nibbles each test sends; a negedge monitor checks handshakes and frame bookkeeping.
module tb_decoder_frame_ctrl;

  localparam int DEC_LAT = 2;
  localparam int NCW [3] = '{2, 3, 4};

  logic       clk = 1'b0;
  logic       reset;
  logic       fs  [3];
  logic       sv  [3];
  logic [1:0] sd  [3];
  logic       br  [3];
  wire        sr  [3];
  wire        den [3];
  wire        bv  [3];
  wire        busy[3];
  wire        done[3];
  wire  [1:0] din [3];
  wire  [7:0] bd  [3];
  wire  [3:0] dout[3];

  logic [1:0] dq   [3][$];
  logic [7:0] expq [3][$];

  bit         tog [3];
  bit         ph  [3];
  bit         acc [3];
  bit         stall_p[3];
  bit         done_p [3];
  bit         have_first[3];
  logic [7:0] stall_bd[3];
  logic [7:0] first_b [3];
  logic [7:0] last_b  [3];
  int         fcnt[3];
  int         run [3];
  int         bvcnt[3];
  int         done_cnt[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_u
    logic [1:0] c;
    logic [1:0] d0, d1;
    logic [3:0] pend, dv;
    int         tmr;

    always @(posedge clk) begin
      if (reset) begin
        c <= 2'd0; tmr <= 0; dv <= 4'h0; pend <= 4'h0; d0 <= 2'd0; d1 <= 2'd0;
      end else begin
        if (tmr != 0) begin
          tmr <= tmr - 1;
          if (tmr == 1) dv <= pend;
        end
        if (den[k]) begin
          c <= c + 2'd1;
          if (c == 2'd0) d0 <= din[k];
          if (c == 2'd1) d1 <= din[k];
          if (c == 2'd3) begin
            if (DEC_LAT == 1) dv <= {d0, d1};
            else begin pend <= {d0, d1}; tmr <= DEC_LAT - 1; end
          end
        end
      end
    end
    assign dout[k] = dv;

    decoder_frame_ctrl #(.NUM_CW(NCW[k]), .DEC_LAT(DEC_LAT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .frame_start(fs[k]),
      .sym_data   (sd[k]),
      .sym_valid  (sv[k]),
      .sym_ready  (sr[k]),
      .dec_in     (din[k]),
      .dec_en     (den[k]),
      .dec_out    (dout[k]),
      .byte_data  (bd[k]),
      .byte_valid (bv[k]),
      .byte_ready (br[k]),
      .frame_busy (busy[k]),
      .frame_done (done[k])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Queue the dibits of n codewords (nibble i at nv[4i+:4]) and the bytes they must produce.
  task automatic push_frame(input int k, input int n, input logic [31:0] nv);
    logic [3:0] nib, prev;
    prev = 4'h0;
    for (int i = 0; i < n; i++) begin
      nib = nv[4*i +: 4];
      dq[k].push_back(nib[3:2]);
      dq[k].push_back(nib[1:0]);
      dq[k].push_back(nib[1:0] ^ 2'b01);
      dq[k].push_back(nib[3:2] ^ 2'b10);
      if (i % 2 == 1)      expq[k].push_back({nib, prev});
      else if (i == n - 1) expq[k].push_back({4'h0, nib});
      prev = nib;
    end
  endtask

  task automatic pulse(input int k);
    fs[k] = 1'b1;
    step(1);
    fs[k] = 1'b0;
  endtask

  task automatic wait_frame(input int k, input string nm);
    int d0 = done_cnt[k];
    int c  = 0;
    while (c < 500 && !(done_cnt[k] > d0 && expq[k].size() == 0)) begin
      step(1);
      c++;
    end
    chk({nm, "_finished"}, 32'(done_cnt[k] > d0 && expq[k].size() == 0), 1);
    step(2);
    chk({nm, "_done_once"}, done_cnt[k] - d0, 1);
  endtask

  // Symbol source: presents queued dibits, optionally every other cycle.
  initial begin
    for (int k = 0; k < 3; k++) begin sv[k] = 1'b0; sd[k] = 2'b00; end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (acc[k] && dq[k].size() > 0) void'(dq[k].pop_front());
        ph[k] = ~ph[k];
        sv[k] = (dq[k].size() > 0) && (!tog[k] || ph[k]);
        sd[k] = (dq[k].size() > 0) ? dq[k][0] : 2'b00;
      end
    end
  end

  // Monitor: every cycle, every instance.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        acc[k] = 0; stall_p[k] = 0; done_p[k] = 0; run[k] = 0;
      end else begin
        bit ok;
        logic [7:0] e;
        if (fs[k] && !busy[k]) begin
          fcnt[k] = 0; bvcnt[k] = 0; have_first[k] = 0;
        end
        run[k] = den[k] ? run[k] + 1 : 0;
        ok = (den[k] === (sv[k] & sr[k])) && (!sr[k] || busy[k]) && (run[k] <= 4) &&
             (!den[k] || (din[k] === sd[k] && fcnt[k] < 4 * NCW[k]));
        chk($sformatf("feed%0d", k), {31'b0, ok}, 1);
        if (den[k]) fcnt[k]++;
        acc[k] = sv[k] & sr[k];
        if (stall_p[k]) chk($sformatf("hold%0d", k), {bv[k], bd[k]}, {1'b1, stall_bd[k]});
        stall_p[k]  = bv[k] & !br[k];
        stall_bd[k] = bd[k];
        if (bv[k]) bvcnt[k]++;
        if (bv[k] && br[k]) begin
          if (expq[k].size() == 0) chk($sformatf("extra_byte%0d", k), bd[k], 32'hFFFF);
          else begin
            e = expq[k].pop_front();
            chk($sformatf("byte%0d", k), bd[k], e);
            last_b[k] = bd[k];
            if (!have_first[k]) first_b[k] = bd[k];
            have_first[k] = 1;
          end
        end
        if (done_p[k]) chk($sformatf("busy_after_done%0d", k), busy[k], 0);
        done_p[k] = done[k];
        if (done[k]) begin
          done_cnt[k]++;
          chk($sformatf("done_dibits%0d", k), fcnt[k], 4 * NCW[k]);
          chk($sformatf("done_tail%0d", k), expq[k].size(), {31'b0, bv[k] & !br[k]});
          chk($sformatf("done_busy%0d", k), busy[k], 1);
        end
      end
    end
  end

  initial begin
    int c;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin fs[k] = 1'b0; br[k] = 1'b1; tog[k] = 0; end
    step(3);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_outs%0d", k), {sr[k], den[k], bv[k], busy[k], done[k], bd[k]}, 0);
    step(1);
    reset = 1'b0;
    step(2);

    // Continuous feed, NUM_CW=2, nibbles A then 5.
    push_frame(0, 2, 32'h5A);
    pulse(0);
    wait_frame(0, "t1");
    chk("t1_byte", first_b[0], 8'h5A);
    chk("t1_bv_cycles", bvcnt[0], 1);

    // Same frame with sym_valid toggling each cycle.
    tog[0] = 1;
    push_frame(0, 2, 32'h5A);
    pulse(0);
    wait_frame(0, "t2");
    chk("t2_byte", last_b[0], 8'h5A);
    tog[0] = 0;

    // Backpressure, NUM_CW=4: sink stalls before the first byte.
    br[2] = 1'b0;
    push_frame(2, 4, 32'h96C3);
    pulse(2);
    c = 0;
    while (c < 200 && !bv[2]) begin step(1); c++; end
    chk("t3_first_valid", {31'b0, bv[2]}, 1);
    step(20);
    @(negedge clk);
    chk("t3_stall_rdy", {31'b0, sr[2]}, 0);
    chk("t3_held_byte", bd[2], 8'hC3);
    chk("t3_all_fed", dq[2].size(), 0);
    step(1);
    br[2] = 1'b1;
    wait_frame(2, "t3");
    chk("t3_first", first_b[2], 8'hC3);
    chk("t3_last", last_b[2], 8'h96);

    // Odd frame, NUM_CW=3, nibbles 1,2,3.
    push_frame(1, 3, 32'h321);
    pulse(1);
    wait_frame(1, "t4");
    chk("t4_first", first_b[1], 8'h21);
    chk("t4_last", last_b[1], 8'h03);

    // Stray frame_start during FEED of codeword 1.
    push_frame(1, 3, 32'hE87);
    pulse(1);
    step(9);
    pulse(1);
    wait_frame(1, "t5");
    chk("t5_first", first_b[1], 8'h87);
    chk("t5_last", last_b[1], 8'h0E);

    // Reset after two dibits, then a fresh frame.
    push_frame(2, 4, 32'h1234);
    pulse(2);
    c = 0;
    while (c < 100 && fcnt[2] < 2) begin step(1); c++; end
    chk("t6_two_dibits", fcnt[2], 2);
    reset = 1'b1;
    dq[2].delete();
    expq[2].delete();
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_reset_outs", {sr[2], den[2], bv[2], busy[2], done[2], bd[2]}, 0);
    step(2);
    push_frame(2, 4, 32'h2DB4);
    pulse(2);
    wait_frame(2, "t6");
    chk("t6_first", first_b[2], 8'hB4);
    chk("t6_last", last_b[2], 8'h2D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
